// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the DSP pre-adder/multiplier input stage.
package dsp_pkg;

  localparam int OP_PREADD = 0;
  localparam int OP_SUB    = 1;

  localparam string B_DIRECT  = "DIRECT";
  localparam string B_CASCADE = "CASCADE";

  function automatic int max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/dsp_delay_line.sv
// N-deep clock-enabled register chain with async reset and a synchronous clear;
// N=0 degenerates to a wire.
module dsp_delay_line #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (N == 0) begin : g_pass
    assign q = d;
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, en, clr};
  end else begin : g_regs
    logic [W-1:0] r_pipe [N];

    // NOTE: every stage is reset, not just the valid bits, because the outputs
    // must read zero during reset; this costs the DSP-internal register packing.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < N; i++) r_pipe[i] <= '0;
      end else if (en) begin
        if (clr) begin
          for (int i = 0; i < N; i++) r_pipe[i] <= '0;
        end else begin
          // NOTE: non-blocking assignments make every stage sample the old
          // value of its predecessor, so the loop order does not matter.
          r_pipe[0] <= d;
          for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign q = r_pipe[N-1];
  end

endmodule

// File: rtl/dsp_preadd_mult_pipe.sv
// DSP input stage: A/B/D/C registers, pre-adder, B cascade and multiplier, with
// automatic path balancing, valid pipeline, global stall and valid flush.
module dsp_preadd_mult_pipe
  import dsp_pkg::*;
#(
  parameter int    AW           = 18,
  parameter int    BW           = 18,
  parameter int    CW           = 48,
  parameter int    A_STAGES     = 2,
  parameter int    BPRE_STAGES  = 1,
  parameter int    BPOST_STAGES = 1,
  parameter int    M_STAGES     = 1,
  parameter string B_INPUT      = B_DIRECT,
  parameter int    SIGNED       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  input  logic [BW-1:0]    bcin,
  input  logic [BW-1:0]    d,
  input  logic [CW-1:0]    c,
  input  logic [1:0]       opmode,
  output logic             out_valid,
  output logic [AW+BW-1:0] m,
  output logic [CW-1:0]    c_out,
  output logic [BW-1:0]    bcout
);

  localparam int   LA   = A_STAGES;
  localparam int   LB   = BPRE_STAGES + BPOST_STAGES;
  localparam int   LAB  = max(LA, LB);
  localparam int   L    = LAB + M_STAGES;
  localparam int   PW   = AW + BW;
  localparam logic SGN  = (SIGNED != 0);
  localparam logic CASC = (B_INPUT == B_CASCADE);

  if (A_STAGES < 0 || A_STAGES > 2)         begin : g_bad_a   $fatal(1, "A_STAGES out of range");     end
  if (BPRE_STAGES < 0 || BPRE_STAGES > 1)   begin : g_bad_bpr $fatal(1, "BPRE_STAGES out of range");  end
  if (BPOST_STAGES < 0 || BPOST_STAGES > 1) begin : g_bad_bpo $fatal(1, "BPOST_STAGES out of range"); end
  if (M_STAGES < 0 || M_STAGES > 2)         begin : g_bad_m   $fatal(1, "M_STAGES out of range");     end
  if (SIGNED < 0 || SIGNED > 1)             begin : g_bad_s   $fatal(1, "SIGNED out of range");       end
  if (B_INPUT != B_DIRECT && B_INPUT != B_CASCADE) begin : g_bad_bi $fatal(1, "bad B_INPUT"); end
  if (AW < 1 || BW < 1 || CW < 1)           begin : g_bad_w   $fatal(1, "widths must be positive");   end

  logic [BW-1:0]     w_b_sel;
  logic [2*BW+1:0]   w_bpre_q;
  logic [1:0]        w_op_r;
  logic [BW-1:0]     w_d_r, w_b_r, w_pre, w_mux, w_b_al;
  logic [AW-1:0]     w_a_r, w_a_al;
  logic [PW-1:0]     w_a_ext, w_b_ext, w_prod;

  assign w_b_sel = CASC ? bcin : b;

  // opmode rides with B/D so each sample carries its own pre-adder mode.
  dsp_delay_line #(.W(2*BW+2), .N(BPRE_STAGES)) u_bpre (
    .clk(clk), .rst_n(rst_n), .en(ce), .clr(1'b0),
    .d({opmode, d, w_b_sel}), .q(w_bpre_q)
  );
  assign {w_op_r, w_d_r, w_b_r} = w_bpre_q;

  assign w_pre = w_op_r[OP_SUB] ? (w_d_r - w_b_r) : (w_d_r + w_b_r);
  assign w_mux = w_op_r[OP_PREADD] ? w_pre : w_b_r;

  dsp_delay_line #(.W(BW), .N(BPOST_STAGES)) u_bpost (
    .clk(clk), .rst_n(rst_n), .en(ce), .clr(1'b0), .d(w_mux), .q(bcout)
  );

  dsp_delay_line #(.W(AW), .N(A_STAGES)) u_a (
    .clk(clk), .rst_n(rst_n), .en(ce), .clr(1'b0), .d(a), .q(w_a_r)
  );

  // Balancing: whichever of the A and B paths is shorter is padded to match.
  dsp_delay_line #(.W(AW), .N(LAB - LA)) u_a_bal (
    .clk(clk), .rst_n(rst_n), .en(ce), .clr(1'b0), .d(w_a_r), .q(w_a_al)
  );
  dsp_delay_line #(.W(BW), .N(LAB - LB)) u_b_bal (
    .clk(clk), .rst_n(rst_n), .en(ce), .clr(1'b0), .d(bcout), .q(w_b_al)
  );

  // Extending both operands to the full product width makes the low PW bits
  // of a plain multiply correct for signed and unsigned alike.
  assign w_a_ext = {{BW{w_a_al[AW-1] & SGN}}, w_a_al};
  assign w_b_ext = {{AW{w_b_al[BW-1] & SGN}}, w_b_al};
  assign w_prod  = w_a_ext * w_b_ext;

  dsp_delay_line #(.W(PW), .N(M_STAGES)) u_m (
    .clk(clk), .rst_n(rst_n), .en(ce), .clr(1'b0), .d(w_prod), .q(m)
  );

  dsp_delay_line #(.W(CW), .N(L)) u_c (
    .clk(clk), .rst_n(rst_n), .en(ce), .clr(1'b0), .d(c), .q(c_out)
  );

  dsp_delay_line #(.W(1), .N(L)) u_valid (
    .clk(clk), .rst_n(rst_n), .en(ce), .clr(flush), .d(in_valid), .q(out_valid)
  );

endmodule

// File: tb/tb_dsp_preadd_mult_pipe.sv
// Directed self-checking bench: default build (L=3), an all-combinational build
// (L=0) and a cascade build with A=2, B=0/0, M=1 (L=3), sharing one stimulus.
module tb_dsp_preadd_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n, ce, flush, in_valid;
  logic [17:0] a, b, bcin, d;
  logic [47:0] c;
  logic [1:0]  opmode;

  logic        v_d, v_z, v_c;
  logic [35:0] m_d, m_z, m_c;
  logic [47:0] co_d, co_z, co_c;
  logic [17:0] bo_d, bo_z, bo_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_preadd_mult_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .in_valid(in_valid),
    .a(a), .b(b), .bcin(bcin), .d(d), .c(c), .opmode(opmode),
    .out_valid(v_d), .m(m_d), .c_out(co_d), .bcout(bo_d)
  );

  dsp_preadd_mult_pipe #(
    .A_STAGES(0), .BPRE_STAGES(0), .BPOST_STAGES(0), .M_STAGES(0)
  ) u_zero (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .in_valid(in_valid),
    .a(a), .b(b), .bcin(bcin), .d(d), .c(c), .opmode(opmode),
    .out_valid(v_z), .m(m_z), .c_out(co_z), .bcout(bo_z)
  );

  dsp_preadd_mult_pipe #(
    .A_STAGES(2), .BPRE_STAGES(0), .BPOST_STAGES(0), .M_STAGES(1), .B_INPUT("CASCADE")
  ) u_casc (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .in_valid(in_valid),
    .a(a), .b(b), .bcin(bcin), .d(d), .c(c), .opmode(opmode),
    .out_valid(v_c), .m(m_c), .c_out(co_c), .bcout(bo_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [17:0] va, input logic [17:0] vd, input logic [17:0] vb,
                       input logic [1:0] vop, input logic [47:0] vc, input logic vv);
    a = va; d = vd; b = vb; opmode = vop; c = vc; in_valid = vv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; flush = 1'b0; bcin = '0;
    drive('0, '0, '0, 2'b00, '0, 1'b0);
    step();
    step();
    total++;
    if ({v_d, m_d, co_d, bo_d} !== '0) begin
      bad++;
      $display("FAIL reset_default: got v=%b m=%h c=%h bc=%h want all 0", v_d, m_d, co_d, bo_d);
    end
    total++;
    if ({v_c, m_c, co_c, bo_c} !== '0) begin
      bad++;
      $display("FAIL reset_cascade: got v=%b m=%h c=%h bc=%h want all 0", v_c, m_c, co_c, bo_c);
    end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    drive(18'd3, 18'd10, 18'd5, 2'b01, 48'd7, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      drive('0, '0, '0, 2'b00, '0, 1'b0);
      if (k < 3) begin
        total++;
        if (v_d !== 1'b0) begin
          bad++;
          $display("FAIL latency_early k=%0d: out_valid=%b want 0", k, v_d);
        end
      end
    end
    total++;
    if (v_d !== 1'b1 || m_d !== 36'd45 || co_d !== 48'd7) begin
      bad++;
      $display("FAIL latency_out: v=%b m=%0d c_out=%0d want v=1 m=45 c_out=7", v_d, m_d, co_d);
    end
    step();
    total++;
    if (v_d !== 1'b0) begin
      bad++;
      $display("FAIL latency_single: out_valid=%b want 0 one cycle after", v_d);
    end
  endtask

  task automatic test_back_to_back();
    drive(-18'sd2, 18'd10, 18'd5, 2'b11, 48'd1, 1'b1);
    step();
    drive(-18'sd2, 18'd99, 18'd7, 2'b00, 48'd2, 1'b1);
    step();
    drive('0, '0, '0, 2'b00, '0, 1'b0);
    step();
    total++;
    if (v_d !== 1'b1 || m_d !== -36'sd10 || co_d !== 48'd1) begin
      bad++;
      $display("FAIL b2b_sub: v=%b m=%h c=%0d want v=1 m=-10 c=1", v_d, m_d, co_d);
    end
    step();
    total++;
    if (v_d !== 1'b1 || m_d !== -36'sd14 || co_d !== 48'd2) begin
      bad++;
      $display("FAIL b2b_bypass: v=%b m=%h c=%0d want v=1 m=-14 c=2", v_d, m_d, co_d);
    end
  endtask

  task automatic test_wrap();
    drive(18'd1, 18'h1FFFF, 18'd1, 2'b01, '0, 1'b1);
    step();
    drive('0, '0, '0, 2'b00, '0, 1'b0);
    step();
    total++;
    if (bo_d !== 18'h20000) begin
      bad++;
      $display("FAIL wrap_bcout: got %h want 20000", bo_d);
    end
    step();
    total++;
    if (m_d !== -36'sd131072 || v_d !== 1'b1) begin
      bad++;
      $display("FAIL wrap_m: got m=%h v=%b want m=%h v=1", m_d, v_d, -36'sd131072);
    end
    step();
  endtask

  task automatic test_stall();
    int idx = 1;
    int got = 0;
    logic [35:0] pm;
    logic [47:0] pc;
    logic        pv;
    for (int cyc = 0; cyc < 20; cyc++) begin
      ce = !(cyc == 5 || cyc == 6);
      if (idx <= 8) drive(18'(idx), '0, 18'(idx), 2'b00, 48'(100 + idx), 1'b1);
      else          drive('0, '0, '0, 2'b00, '0, 1'b0);
      pm = m_d; pc = co_d; pv = v_d;
      step();
      if (ce && idx <= 8) idx++;
      if (!ce) begin
        total++;
        if (m_d !== pm || co_d !== pc || v_d !== pv) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d: m=%0d c=%0d v=%b want m=%0d c=%0d v=%b",
                   cyc, m_d, co_d, v_d, pm, pc, pv);
        end
      end else if (v_d) begin
        got++;
        total++;
        if (m_d !== 36'(got * got) || co_d !== 48'(100 + got)) begin
          bad++;
          $display("FAIL stall_seq #%0d: m=%0d c=%0d want m=%0d c=%0d",
                   got, m_d, co_d, got * got, 100 + got);
        end
      end
    end
    ce = 1'b1;
    total++;
    if (got !== 8) begin
      bad++;
      $display("FAIL stall_count: got %0d outputs want 8", got);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    drive(18'd2, '0, 18'd2, 2'b00, '0, 1'b1);
    step();
    flush = 1'b1;
    drive(18'd3, '0, 18'd3, 2'b00, '0, 1'b1);
    step();
    flush = 1'b0;
    drive('0, '0, '0, 2'b00, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (v_d) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL flush: %0d valid outputs after flush, want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    drive(18'd3, 18'd10, 18'd5, 2'b01, 48'd7, 1'b1);
    step();
    step();
    step();
    drive('0, '0, '0, 2'b00, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({v_d, m_d, co_d, bo_d} !== '0) begin
      bad++;
      $display("FAIL async_reset: v=%b m=%h c=%h bc=%h want all 0", v_d, m_d, co_d, bo_d);
    end
    #2 rst_n = 1'b1;
    step();
    drive(18'd4, 18'd1, 18'd1, 2'b01, 48'd9, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      drive('0, '0, '0, 2'b00, '0, 1'b0);
      if (k < 3) begin
        total++;
        if (v_d !== 1'b0) begin
          bad++;
          $display("FAIL post_reset_early k=%0d: out_valid=%b want 0", k, v_d);
        end
      end
    end
    total++;
    if (v_d !== 1'b1 || m_d !== 36'd8 || co_d !== 48'd9) begin
      bad++;
      $display("FAIL post_reset_out: v=%b m=%0d c=%0d want v=1 m=8 c=9", v_d, m_d, co_d);
    end
  endtask

  task automatic test_depth_variants();
    drive(18'd3, 18'd10, 18'd5, 2'b01, 48'd7, 1'b1);
    #1;
    total++;
    if (v_z !== 1'b1 || m_z !== 36'd45 || co_z !== 48'd7 || bo_z !== 18'd15) begin
      bad++;
      $display("FAIL comb_add: v=%b m=%0d c=%0d bc=%0d want 1 45 7 15", v_z, m_z, co_z, bo_z);
    end
    opmode = 2'b11;
    in_valid = 1'b0;
    #1;
    total++;
    if (v_z !== 1'b0 || m_z !== 36'd15) begin
      bad++;
      $display("FAIL comb_sub: v=%b m=%0d want v=0 m=15", v_z, m_z);
    end
    step();
    bcin = 18'd4;
    drive(18'd5, 18'd6, 18'd100, 2'b01, 48'd11, 1'b1);
    #1;
    total++;
    if (bo_c !== 18'd10) begin
      bad++;
      $display("FAIL casc_bcout: got %0d want 10", bo_c);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      drive('0, '0, '0, 2'b00, '0, 1'b0);
      bcin = '0;
      if (k < 3) begin
        total++;
        if (v_c !== 1'b0) begin
          bad++;
          $display("FAIL casc_early k=%0d: out_valid=%b want 0", k, v_c);
        end
      end
    end
    total++;
    if (v_c !== 1'b1 || m_c !== 36'd50 || co_c !== 48'd11) begin
      bad++;
      $display("FAIL casc_out: v=%b m=%0d c=%0d want v=1 m=50 c=11", v_c, m_c, co_c);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_wrap();
    test_stall();
    test_flush();
    test_async_reset();
    test_depth_variants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
